// File: rtl/dac_pkg.sv
// Shared status codes, FSM state encoding and width helper for the
// multichannel slewed DAC front end.
package dac_pkg;

  localparam logic [3:0] STATUS_RESET = 4'b0000;
  localparam logic [3:0] STATUS_MUTE  = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_INIT = 2'b01,
    ST_RUN       = 2'b10,
    ST_MUTE      = 2'b11
  } state_e;

  // Bits needed to hold the values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dac_multich_slew_if.sv
// Frame handshake bus: flattened N-channel target frame with valid/ready.
interface dac_multich_slew_if #(
  parameter int unsigned NB_CHANNELS = 2,
  parameter int unsigned DATA_W      = 14
);
  logic [NB_CHANNELS*DATA_W-1:0] data;
  logic                          valid;
  logic                          ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/dac_slew_limiter.sv
// One DAC channel: target register, slew-limited output register and a
// settled flag (output equals latched target).
module dac_slew_limiter #(
  parameter int unsigned DATA_W    = 14,
  parameter int unsigned SLEW_STEP = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              slew_en_i,
  input  logic              force_zero_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] out_o,
  output logic              settled_o
);

  localparam logic [DATA_W:0]   STEP_X = (DATA_W+1)'(SLEW_STEP);
  localparam logic [DATA_W-1:0] STEP_W = DATA_W'(SLEW_STEP);

  logic [DATA_W-1:0] target_q, target_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] eff_target;
  logic [DATA_W:0]   diff;
  logic [DATA_W:0]   mag;

  always_comb begin
    eff_target = force_zero_i ? '0 : target_q;
    // Sign-extend both operands so the difference never wraps.
    diff = {eff_target[DATA_W-1], eff_target} - {out_q[DATA_W-1], out_q};
    mag  = diff[DATA_W] ? (~diff + 1'b1) : diff;

    target_d = target_q;
    out_d    = out_q;
    if (clear_i) begin
      target_d = '0;
      out_d    = '0;
    end else begin
      if (force_zero_i)
        target_d = '0;
      else if (load_i)
        target_d = data_i;
      if (slew_en_i) begin
        if (mag <= STEP_X)
          out_d = eff_target;
        else if (diff[DATA_W])
          out_d = out_q - STEP_W;
        else
          out_d = out_q + STEP_W;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
      out_q    <= '0;
    end else begin
      target_q <= target_d;
      out_q    <= out_d;
    end
  end

  assign out_o     = out_q;
  assign settled_o = (out_q == target_q);

endmodule

// File: rtl/dac_multich_slew.sv
// N-channel DAC front end: init/IAGC gating FSM, init timeout and frame
// handshake driving one slew limiter per channel.
module dac_multich_slew
  import dac_pkg::*;
#(
  parameter int unsigned NB_CHANNELS      = 2,
  parameter int unsigned ZMOD_DATA_SIZE   = 14,
  parameter int unsigned IAGC_STATUS_SIZE = 4,
  parameter int unsigned SLEW_STEP        = 64,
  parameter int unsigned INIT_TIMEOUT     = 1023
) (
  input  logic                                  i_sys_clock,
  input  logic                                  i_reset_n,
  input  logic [IAGC_STATUS_SIZE-1:0]           i_iagc_status,
  dac_multich_slew_if.slave                     s_if,
  input  logic                                  i_dac_init_done,
  output logic [NB_CHANNELS*ZMOD_DATA_SIZE-1:0] o_data,
  output logic                                  o_data_valid,
  output logic [1:0]                            o_state,
  output logic                                  o_timeout
);

  localparam int unsigned CW = cnt_width(INIT_TIMEOUT);
  localparam logic [CW-1:0] TO_CNT = CW'(INIT_TIMEOUT);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                to_q, to_d;
  logic                is_reset, is_mute;
  logic                clear, slew_en, force_zero, load;
  logic [NB_CHANNELS-1:0] settled;

  assign is_reset = (i_iagc_status == IAGC_STATUS_SIZE'(STATUS_RESET));
  assign is_mute  = (i_iagc_status == IAGC_STATUS_SIZE'(STATUS_MUTE));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      state_d = ST_WAIT_INIT;
      ST_WAIT_INIT: if (i_dac_init_done) state_d = is_mute ? ST_MUTE : ST_RUN;
      ST_RUN:       if (is_mute) state_d = ST_MUTE;
      ST_MUTE:      if (!is_mute) state_d = ST_RUN;
      default:      state_d = ST_IDLE;
    endcase
    if (is_reset)
      state_d = ST_IDLE;
  end

  // Status changes act on the very next edge, so mute/clear look at the
  // live status as well as the registered state.
  assign clear      = is_reset || (state_q == ST_IDLE);
  assign slew_en    = (state_q == ST_RUN) || (state_q == ST_MUTE);
  assign force_zero = (state_q == ST_MUTE) || ((state_q == ST_RUN) && is_mute);
  assign s_if.ready = (state_q == ST_RUN) && (&settled);
  assign load       = s_if.valid && s_if.ready;

  always_comb begin
    cnt_d = cnt_q;
    to_d  = to_q;
    if (clear) begin
      cnt_d = '0;
      to_d  = 1'b0;
    end else begin
      if ((state_q == ST_WAIT_INIT) && (cnt_q != TO_CNT))
        cnt_d = cnt_q + 1'b1;
      to_d = to_q || (cnt_d == TO_CNT);
    end
  end

  always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  for (genvar k = 0; k < NB_CHANNELS; k++) begin : g_ch
    dac_slew_limiter #(
      .DATA_W    (ZMOD_DATA_SIZE),
      .SLEW_STEP (SLEW_STEP)
    ) u_slew (
      .clk          (i_sys_clock),
      .rst_n        (i_reset_n),
      .clear_i      (clear),
      .slew_en_i    (slew_en),
      .force_zero_i (force_zero),
      .load_i       (load),
      .data_i       (s_if.data[k*ZMOD_DATA_SIZE +: ZMOD_DATA_SIZE]),
      .out_o        (o_data[k*ZMOD_DATA_SIZE +: ZMOD_DATA_SIZE]),
      .settled_o    (settled[k])
    );
  end

  assign o_data_valid = (state_q == ST_RUN) || (state_q == ST_MUTE);
  assign o_state      = state_q;
  assign o_timeout    = to_q;

endmodule

// File: tb/tb_dac_multich_slew.sv
// Directed bench for dac_multich_slew (2 channels, 14-bit, step 64, timeout 1023).
module tb_dac_multich_slew;

  localparam int W = 14;

  logic          clk;
  logic          rst_n;
  logic [3:0]    status;
  logic          init_done;
  logic [2*W-1:0] o_data;
  logic          o_data_valid;
  logic [1:0]    o_state;
  logic          o_timeout;

  int n_cmp = 0;
  int n_err = 0;

  dac_multich_slew_if #(.NB_CHANNELS(2), .DATA_W(W)) bus ();

  dac_multich_slew #(
    .NB_CHANNELS      (2),
    .ZMOD_DATA_SIZE   (W),
    .IAGC_STATUS_SIZE (4),
    .SLEW_STEP        (64),
    .INIT_TIMEOUT     (1023)
  ) dut (
    .i_sys_clock     (clk),
    .i_reset_n       (rst_n),
    .i_iagc_status   (status),
    .s_if            (bus),
    .i_dac_init_done (init_done),
    .o_data          (o_data),
    .o_data_valid    (o_data_valid),
    .o_state         (o_state),
    .o_timeout       (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [W-1:0] ch(input int k);
    return o_data[k*W +: W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input int c0, input int c1);
    bus.data = {W'(c1), W'(c0)};
  endtask

  // Bounded wait for o_ready; an expired bound is a failed comparison.
  task automatic wait_ready(input string name, input int bound);
    int n = 0;
    while (!bus.ready && n < bound) begin
      step();
      n++;
    end
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s: o_ready=%b after %0d cycles, required 1", name, bus.ready, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; status = 4'b0000; init_done = 1'b0;
    bus.valid = 1'b0; set_frame(0, 0);
    #23;
    n_cmp++; if (o_data !== '0) begin n_err++; $display("FAIL reset_data: got %h required 0", o_data); end
    n_cmp++; if (o_state !== 2'b00) begin n_err++; $display("FAIL reset_state: got %b required 00", o_state); end
    n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b required 0", bus.ready); end
    n_cmp++; if (o_data_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", o_data_valid); end
    n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b required 0", o_timeout); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++; if (o_state !== 2'b00) begin n_err++; $display("FAIL idle_hold: got %b required 00", o_state); end
  endtask

  task automatic test_init();
    status = 4'b0010;
    for (int i = 1; i <= 5; i++) begin
      step();
      n_cmp++;
      if (o_state !== 2'b01) begin n_err++; $display("FAIL init_wait[%0d]: state %b required 01", i, o_state); end
    end
    init_done = 1'b1;
    step();
    n_cmp++; if (o_state !== 2'b10) begin n_err++; $display("FAIL init_run: state %b required 10", o_state); end
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL init_ready: got %b required 1", bus.ready); end
    n_cmp++; if (o_data_valid !== 1'b1) begin n_err++; $display("FAIL init_valid: got %b required 1", o_data_valid); end
    n_cmp++; if (o_data !== '0) begin n_err++; $display("FAIL init_data: got %h required 0", o_data); end
  endtask

  task automatic test_ramp();
    logic signed [W-1:0] e0;
    set_frame(1000, -1000); bus.valid = 1'b1;
    step();
    bus.valid = 1'b0;
    n_cmp++; if (ch(0) !== 14'sd0) begin n_err++; $display("FAIL ramp_latency: ch0=%0d required 0", ch(0)); end
    n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL ramp_ready_drop: got %b required 0", bus.ready); end
    for (int i = 1; i <= 16; i++) begin
      step();
      e0 = (i == 16) ? 14'sd1000 : W'(64 * i);
      n_cmp++; if (ch(0) !== e0) begin n_err++; $display("FAIL ramp_ch0[%0d]: got %0d required %0d", i, ch(0), e0); end
      n_cmp++; if (ch(1) !== -e0) begin n_err++; $display("FAIL ramp_ch1[%0d]: got %0d required %0d", i, ch(1), -e0); end
      n_cmp++; if (bus.ready !== (i == 16)) begin n_err++; $display("FAIL ramp_ready[%0d]: got %b required %b", i, bus.ready, (i == 16)); end
    end
  endtask

  task automatic test_fullscale();
    logic signed [W-1:0] prev;
    logic signed [W-1:0] e0;
    int moves = 0;
    set_frame(-8192, 0); bus.valid = 1'b1;
    step();
    bus.valid = 1'b0;
    wait_ready("fs_neg_settle", 300);
    n_cmp++; if (ch(0) !== -14'sd8192) begin n_err++; $display("FAIL fs_neg: ch0=%0d required -8192", ch(0)); end
    set_frame(8191, 0); bus.valid = 1'b1;
    step();
    bus.valid = 1'b0;
    e0 = -14'sd8192;
    for (int i = 1; i <= 256; i++) begin
      prev = ch(0);
      step();
      e0 = (i == 256) ? 14'sd8191 : W'(-8192 + 64 * i);
      n_cmp++;
      if (ch(0) !== e0 || ch(0) <= prev) begin
        n_err++; $display("FAIL fs_step[%0d]: got %0d required %0d", i, ch(0), e0);
      end
      moves++;
    end
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL fs_ready: got %b after %0d edges required 1", bus.ready, moves); end
    n_cmp++; if (ch(1) !== 14'sd0) begin n_err++; $display("FAIL fs_ch1: got %0d required 0", ch(1)); end
  endtask

  task automatic test_mute();
    logic signed [W-1:0] e0;
    set_frame(0, 0); bus.valid = 1'b1;
    step();
    bus.valid = 1'b0;
    wait_ready("mute_pre_settle", 300);
    set_frame(1000, 0); bus.valid = 1'b1;
    step();
    bus.valid = 1'b0;
    repeat (8) step();
    n_cmp++; if (ch(0) !== 14'sd512) begin n_err++; $display("FAIL mute_pre: ch0=%0d required 512", ch(0)); end
    status = 4'b0001; set_frame(5000, 3000); bus.valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      e0 = W'(512 - 64 * i);
      n_cmp++; if (ch(0) !== e0) begin n_err++; $display("FAIL mute_ramp[%0d]: got %0d required %0d", i, ch(0), e0); end
      n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL mute_ready[%0d]: got %b required 0", i, bus.ready); end
    end
    n_cmp++; if (o_state !== 2'b11) begin n_err++; $display("FAIL mute_state: got %b required 11", o_state); end
    n_cmp++; if (o_data_valid !== 1'b1) begin n_err++; $display("FAIL mute_valid: got %b required 1", o_data_valid); end
    repeat (3) step();
    n_cmp++; if (o_data !== '0) begin n_err++; $display("FAIL mute_ignore: got %h required 0", o_data); end
    status = 4'b0010; bus.valid = 1'b0;
    step();
    n_cmp++; if (o_state !== 2'b10) begin n_err++; $display("FAIL unmute_state: got %b required 10", o_state); end
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL unmute_ready: got %b required 1", bus.ready); end
    n_cmp++; if (o_data !== '0) begin n_err++; $display("FAIL unmute_data: got %h required 0", o_data); end
  endtask

  task automatic test_idle_clear();
    set_frame(1000, -1000); bus.valid = 1'b1;
    step();
    bus.valid = 1'b0;
    repeat (3) step();
    n_cmp++; if (ch(0) !== 14'sd192) begin n_err++; $display("FAIL clr_pre: ch0=%0d required 192", ch(0)); end
    status = 4'b0000;
    step();
    n_cmp++; if (o_data !== '0) begin n_err++; $display("FAIL clr_data: got %h required 0", o_data); end
    n_cmp++; if (o_state !== 2'b00) begin n_err++; $display("FAIL clr_state: got %b required 00", o_state); end
  endtask

  task automatic test_timeout();
    init_done = 1'b0; status = 4'b0010;
    step();
    n_cmp++; if (o_state !== 2'b01) begin n_err++; $display("FAIL to_enter: state %b required 01", o_state); end
    n_cmp++; if (o_data_valid !== 1'b0) begin n_err++; $display("FAIL to_valid: got %b required 0", o_data_valid); end
    repeat (1022) step();
    n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL to_early: got %b required 0", o_timeout); end
    step();
    n_cmp++; if (o_timeout !== 1'b1) begin n_err++; $display("FAIL to_set: got %b required 1", o_timeout); end
    repeat (5) step();
    n_cmp++; if (o_timeout !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b required 1", o_timeout); end
    n_cmp++; if (o_state !== 2'b01) begin n_err++; $display("FAIL to_state: got %b required 01", o_state); end
    status = 4'b0000;
    step();
    n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL to_clear: got %b required 0", o_timeout); end
    n_cmp++; if (o_state !== 2'b00) begin n_err++; $display("FAIL to_idle: got %b required 00", o_state); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_ramp();
    test_fullscale();
    test_mute();
    test_idle_clear();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
